// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one ALU operation over valid/ready, drives the
// serial-load ALU (clear, start, A/Q, M), waits for finish or timeout, and
// returns the captured result over a valid/ready response.
`timescale 1ns/1ps
module alu_sequencer #(
    parameter int unsigned TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [15:0] req_opa,
    input  logic [7:0]  req_opb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_of,
    output logic        rsp_timeout,
    output logic        alu_rst,
    output logic        alu_start,
    output logic [1:0]  alu_sel,
    output logic [15:0] alu_inbus,
    input  logic [15:0] alu_outbus,
    input  logic        alu_finish,
    input  logic        alu_of_flag
);

    localparam int unsigned TMO_W  = 8;
    localparam int unsigned DATA_W = 16;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CLR, S_START, S_HOLD, S_LOADM, S_WAIT, S_SETTLE, S_ABORT, S_RESP
    } state_e;

    typedef struct packed {
        logic [1:0]  op;
        logic [15:0] opa;
        logic [7:0]  opb;
    } req_t;

    state_e              state_q, state_d;
    req_t                req_q, req_d;
    logic                sticky_q, sticky_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                mcnt_q, mcnt_d;

    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_of_q, rsp_of_d;
    logic                rsp_timeout_q, rsp_timeout_d;
    logic                alu_rst_q, alu_rst_d;
    logic                alu_start_q, alu_start_d;
    logic [1:0]          alu_sel_q, alu_sel_d;
    logic [DATA_W-1:0]   alu_inbus_q, alu_inbus_d;

    logic accept;
    logic of_window;

    assign accept    = req_valid & req_ready_q;
    assign of_window = (state_q == S_START) || (state_q == S_HOLD) || (state_q == S_LOADM) ||
                       (state_q == S_WAIT)  || (state_q == S_SETTLE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = S_CLR;
            S_CLR:    state_d = S_START;
            S_START:  state_d = S_HOLD;
            S_HOLD:   state_d = S_LOADM;
            S_LOADM:  if (mcnt_q) state_d = S_WAIT;
            S_WAIT: begin
                if (alu_finish) begin
                    state_d = S_SETTLE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_ABORT;
                end
            end
            S_SETTLE: state_d = S_RESP;
            S_ABORT:  state_d = S_RESP;
            S_RESP:   if (rsp_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Request latch, sticky overflow, M-cycle and timeout counters
    always_comb begin
        req_d    = req_q;
        sticky_d = sticky_q;
        tmo_d    = tmo_q;
        mcnt_d   = 1'b0;
        if (state_q == S_IDLE && accept) begin
            req_d    = '{op: req_op, opa: req_opa, opb: req_opb};
            sticky_d = 1'b0;
            tmo_d    = '0;
        end
        if (state_q == S_LOADM) begin
            mcnt_d = ~mcnt_q;
        end
        if (state_q == S_WAIT) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
        // mul/div never report overflow
        if (of_window && alu_of_flag && !req_q.op[1]) begin
            sticky_d = 1'b1;
        end
    end

    // Output next values: ALU pins follow the state being entered, response
    // registers load on leaving SETTLE/ABORT and drop when consumed
    always_comb begin
        req_ready_d   = (state_d == S_IDLE);
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_of_d      = rsp_of_q;
        rsp_timeout_d = rsp_timeout_q;
        alu_rst_d     = 1'b0;
        alu_start_d   = 1'b0;
        alu_sel_d     = alu_sel_q;
        alu_inbus_d   = alu_inbus_q;

        case (state_d)
            S_CLR: begin
                alu_rst_d   = 1'b1;
                alu_sel_d   = '0;
                alu_inbus_d = '0;
            end
            S_START: begin
                alu_start_d = 1'b1;
                alu_sel_d   = req_q.op;
                alu_inbus_d = (req_q.op == 2'b11) ? req_q.opa : {8'h00, req_q.opa[7:0]};
            end
            S_LOADM, S_WAIT: begin
                alu_sel_d   = req_q.op;
                alu_inbus_d = {8'h00, req_q.opb};
            end
            default: ;
        endcase

        case (state_q)
            S_SETTLE: begin
                rsp_data_d    = alu_outbus;
                rsp_of_d      = sticky_d;
                rsp_timeout_d = 1'b0;
                rsp_valid_d   = 1'b1;
            end
            S_ABORT: begin
                rsp_data_d    = '0;
                rsp_of_d      = 1'b0;
                rsp_timeout_d = 1'b1;
                rsp_valid_d   = 1'b1;
            end
            S_RESP: if (rsp_ready) rsp_valid_d = 1'b0;
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q         <= '0;
            sticky_q      <= 1'b0;
            tmo_q         <= '0;
            mcnt_q        <= 1'b0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_of_q      <= 1'b0;
            rsp_timeout_q <= 1'b0;
            alu_rst_q     <= 1'b0;
            alu_start_q   <= 1'b0;
            alu_sel_q     <= '0;
            alu_inbus_q   <= '0;
        end else begin
            req_q         <= req_d;
            sticky_q      <= sticky_d;
            tmo_q         <= tmo_d;
            mcnt_q        <= mcnt_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_of_q      <= rsp_of_d;
            rsp_timeout_q <= rsp_timeout_d;
            alu_rst_q     <= alu_rst_d;
            alu_start_q   <= alu_start_d;
            alu_sel_q     <= alu_sel_d;
            alu_inbus_q   <= alu_inbus_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_of      = rsp_of_q;
    assign rsp_timeout = rsp_timeout_q;
    assign alu_rst     = alu_rst_q;
    assign alu_start   = alu_start_q;
    assign alu_sel     = alu_sel_q;
    assign alu_inbus   = alu_inbus_q;

endmodule
